i2c_slave_sdalogic: RTL
=======================

// Module: i2c_slave_sdalogic
// PURPOSE
// - I2C target (responder) side of the I2C master SDA logic. Listens on SCL/SDA and decodes
//   START, 7-bit address, R/W, memory pointer and data bytes. Drives ACK and read data
//   through an open-drain enable.
// - Sits between the board pins (top-level tristate: SDA = sda_oe ? 1'b0 : 1'bz) and a
//   byte-addressed register file.
// PARAMETERS
// - SYNC_STAGES  2  input synchronizer depth for scl_in/sda_in (>=2)
// - AUTO_INC     1  1: mem_ptr increments after every data byte, wrapping 0xFF->0x00; 0: fixed
// PORTS
// - sda_clk     in   1  block clock; must be >= 8x SCL frequency
// - reset       in   1  asynchronous, active-high
// - scl_in      in   1  SCL pin level (asynchronous)
// - sda_in      in   1  SDA pin level (asynchronous)
// - own_addr    in   7  this target's address; static while busy
// - tx_data     in   8  read byte for mem_ptr; must be valid in the cycle tx_req=1
// - sda_oe      out  1  1 = pull SDA low, 0 = release
// - mem_ptr     out  8  current memory pointer (from write mem byte, then auto-inc)
// - rx_data     out  8  last received data byte; valid when rx_valid=1
// - rx_valid    out  1  1-cycle pulse per received write data byte (address = mem_ptr that cycle)
// - tx_req      out  1  1-cycle pulse: tx_data is captured into the shift register
// - busy        out  1  1 from a matched address ACK until STOP or a new START
// BEHAVIOUR
// - Reset: sda_oe=0, mem_ptr=0, rx_data=0, rx_valid=0, tx_req=0, busy=0, state=IDLE.
//   Reset is asynchronous; asserting it mid-transfer releases SDA immediately.
// - Inputs pass through SYNC_STAGES flops. Edges are detected on synchronized levels:
//   - START: sda falls while scl=1.
//   - STOP: sda rises while scl=1.
//   - Bits are sampled on the scl rise.
//   - sda_oe changes only on the cycle after a detected scl fall.
// - Bit counter is 3 bits, MSB first. The byte completes on the 8th scl rise.
// - States:
//   - IDLE     wait for START
//   - ADDR     shift 7 addr bits + R/W. After the 8th bit:
//              - addr == own_addr: go to ACK_A.
//              - otherwise: go to WAIT_STOP with sda_oe kept at 0.
//   - ACK_A    sda_oe=1 for one SCL period; busy<=1. At the closing scl fall:
//              - W: go to MEM.
//              - R: pulse tx_req, load tx_data, go to RDATA.
//   - MEM      shift 8 bits into mem_ptr, then ACK_M (drive ACK), then WDATA.
//   - WDATA    shift 8 bits. At the 8th rise: rx_data<=byte, pulse rx_valid.
//              Then ACK_D; at its closing scl fall, mem_ptr += AUTO_INC.
//              Then back to WDATA.
//   - RDATA    drive sda_oe = ~shift[7] per bit; shift at each scl fall.
//              After 8 bits, release SDA and go to RACK.
//   - RACK     sample master bit at scl rise:
//              - 0 (ACK): mem_ptr += AUTO_INC, then at the scl fall pulse tx_req
//                (tx_data read at the new mem_ptr), go to RDATA.
//              - 1 (NACK): go to WAIT_STOP.
//   - WAIT_STOP  sda_oe=0; leave only on STOP or START.
// - START in any state (repeated start):
//   - go to ADDR with counter=0, sda_oe=0, busy=0.
//   - mem_ptr is kept, so write-mem-then-read works.
// - STOP in any state:
//   - go to IDLE, sda_oe=0, busy=0.
//   - A partial byte is discarded, with no rx_valid.
// - START and a bit sample in the same cycle: START wins.
// - Address 0x00 (general call) is treated as an ordinary address compare.
// - mem_ptr arithmetic is 8-bit modulo 256; 0xFF+1 = 0x00.
// - Clock stretching is not supported; SCL is never driven.
// TESTING
// - Write: START, 0x50+W, mem 0x10, data 0xA5, STOP (own_addr=0x50)
//   -> ACK at 3 ACK slots; rx_valid once with rx_data=0xA5, mem_ptr=0x10;
//      mem_ptr=0x11 after the ACK.
// - Burst write: mem 0xFF, data 0x11, 0x22
//   -> rx_valid at mem_ptr 0xFF then 0x00 (wrap); busy=0 after STOP.
// - Mismatch: START, 0x51+W, 2 bytes, STOP
//   -> sda_oe=0 throughout; no rx_valid, no tx_req; busy stays 0.
// - Read: write mem 0x20, Sr, 0x50+R; tx_data=0x96; master NACK
//   -> tx_req with mem_ptr=0x20; sda_oe per bit = 0,1,1,0,1,0,0,1; released at RACK; IDLE after STOP.
// - Read burst with master ACK then NACK
//   -> second tx_req with mem_ptr=0x21; no third tx_req.
// - Reset asserted mid-data-byte while sda_oe=1
//   -> sda_oe=0 in the same cycle; all outputs take their reset values.
// - STOP injected after 4 bits of WDATA
//   -> no rx_valid; state IDLE; next transaction decodes normally.

Source files
------------

// File: rtl/i2c_slave_sdalogic.sv
// I2C target SDA engine: decodes START/STOP, address, memory pointer and data bytes
// from synchronized SCL/SDA, and drives ACK and read data through an open-drain enable.
module i2c_slave_sdalogic #(
    parameter int SYNC_STAGES = 2,
    parameter bit AUTO_INC    = 1'b1
) (
    input  logic       sda_clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    input  logic [6:0] own_addr,
    input  logic [7:0] tx_data,
    output logic       sda_oe,
    output logic [7:0] mem_ptr,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_req,
    output logic       busy
);
    typedef enum logic [3:0] {
        IDLE, ADDR, ACK_A, MEM, ACK_M, WDATA, ACK_D, RDATA, RACK, WAIT_STOP
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_prev_q, sda_prev_q;
    logic                   scl_s, sda_s;
    logic                   scl_rise, scl_fall, start_det, stop_det;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       done_q, done_d;       // byte complete / ACK sampled, waiting for scl fall
    logic [7:0] shift_q, shift_d;
    logic [7:0] mem_ptr_q, mem_ptr_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       sda_oe_q, sda_oe_d;
    logic       busy_q, busy_d;
    logic       tx_req_c;
    logic [7:0] rx_byte, ptr_inc;

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
    assign rx_byte   = {shift_q[6:0], sda_s};
    assign ptr_inc   = mem_ptr_q + {7'd0, AUTO_INC};

    // Synchronizers reset to the idle-bus level so reset release never looks like START.
    always_ff @(posedge sda_clk or posedge reset) begin
        if (reset) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    always_ff @(posedge sda_clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            shift_q    <= '0;
            mem_ptr_q  <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            shift_q    <= shift_d;
            mem_ptr_q  <= mem_ptr_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path infers a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        done_d     = done_q;
        shift_d    = shift_q;
        mem_ptr_d  = mem_ptr_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;
        tx_req_c   = 1'b0;

        if (start_det) begin
            state_d  = ADDR;
            cnt_d    = '0;
            done_d   = 1'b0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (stop_det) begin
            state_d  = IDLE;
            cnt_d    = '0;
            done_d   = 1'b0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            unique case (state_q)
                ADDR, MEM, WDATA: begin
                    if (scl_rise) begin
                        shift_d = rx_byte;
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            done_d = 1'b1;
                            if (state_q == ADDR && shift_q[6:0] != own_addr) begin
                                state_d = WAIT_STOP;
                                done_d  = 1'b0;
                            end
                            if (state_q == MEM) mem_ptr_d = rx_byte;
                            if (state_q == WDATA) begin
                                rx_data_d  = rx_byte;
                                rx_valid_d = 1'b1;
                            end
                        end
                    end else if (scl_fall && done_q) begin
                        done_d   = 1'b0;
                        sda_oe_d = 1'b1;
                        if (state_q == ADDR) begin
                            state_d = ACK_A;
                            busy_d  = 1'b1;
                        end else if (state_q == MEM) begin
                            state_d = ACK_M;
                        end else begin
                            state_d = ACK_D;
                        end
                    end
                end
                ACK_A: begin
                    if (scl_fall) begin
                        if (shift_q[0]) begin
                            tx_req_c = 1'b1;
                            shift_d  = tx_data;
                            sda_oe_d = ~tx_data[7];
                            state_d  = RDATA;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = MEM;
                        end
                    end
                end
                ACK_M, ACK_D: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        state_d  = WDATA;
                        if (state_q == ACK_D) mem_ptr_d = ptr_inc;
                    end
                end
                RDATA: begin
                    if (scl_rise) begin
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) done_d = 1'b1;
                    end else if (scl_fall) begin
                        if (done_q) begin
                            done_d   = 1'b0;
                            sda_oe_d = 1'b0;
                            state_d  = RACK;
                        end else begin
                            shift_d  = {shift_q[6:0], shift_q[7]};
                            sda_oe_d = ~shift_q[6];
                        end
                    end
                end
                RACK: begin
                    if (scl_rise) begin
                        if (!sda_s) begin
                            done_d    = 1'b1;
                            mem_ptr_d = ptr_inc;
                        end else begin
                            state_d = WAIT_STOP;
                        end
                    end else if (scl_fall && done_q) begin
                        done_d   = 1'b0;
                        tx_req_c = 1'b1;
                        shift_d  = tx_data;
                        sda_oe_d = ~tx_data[7];
                        state_d  = RDATA;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sda_oe   = sda_oe_q;
    assign mem_ptr  = mem_ptr_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign tx_req   = tx_req_c;
    assign busy     = busy_q;
endmodule
